// File: rtl/pl_reset_sequencer.sv
// Staged PL reset release: synchronizes the CIPS reset request and clock-wizard lock,
// then releases bus-structure, interconnect and peripheral resets in order.
module pl_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic       clk_in1,
    input  logic       reset,
    input  logic       ext_reset_in,
    input  logic       dcm_locked,
    output logic       bus_struct_reset,
    output logic       interconnect_aresetn,
    output logic       peripheral_aresetn,
    output logic       peripheral_reset,
    output logic       seq_done,
    output logic [7:0] release_count
);

    localparam int MAX_COUNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);
    localparam int LOCK_W    = $clog2(LOCK_FILTER + 1);

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_FILTER);

    typedef enum logic [1:0] {
        HOLD,
        REL_BUS,
        REL_IC,
        RUN
    } state_t;

    logic [SYNC_STAGES-1:0] ext_sr;
    logic [SYNC_STAGES-1:0] lock_sr;
    logic                   ext_sync;
    logic                   locked_sync;
    logic [LOCK_W-1:0]      lock_cnt;
    logic [LOCK_W-1:0]      lock_cnt_next;
    logic                   lock_ok;
    logic                   req;
    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   count_release;

    // Clearing the synchronizers makes the inputs read as "reset requested, not locked".
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            ext_sr  <= '0;
            lock_sr <= '0;
        end else begin
            ext_sr  <= {ext_sr[SYNC_STAGES-2:0], ext_reset_in};
            lock_sr <= {lock_sr[SYNC_STAGES-2:0], dcm_locked};
        end
    end

    assign ext_sync    = ext_sr[SYNC_STAGES-1];
    assign locked_sync = lock_sr[SYNC_STAGES-1];

    always_comb begin
        lock_cnt_next = '0;
        if (locked_sync) begin
            lock_cnt_next = (lock_cnt == LOCK_FULL) ? LOCK_FULL : lock_cnt + LOCK_W'(1);
        end
    end

    always_ff @(posedge clk_in1) begin
        if (reset) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt_next;
        end
    end

    // Lock qualifies on the sample that completes the run, not one cycle later.
    assign lock_ok = (lock_cnt_next == LOCK_FULL);
    assign req     = !ext_sync || !lock_ok;

    always_comb begin
        state_next    = state;
        cnt_next      = cnt + CNT_W'(1);
        count_release = 1'b0;
        if (req) begin
            state_next = HOLD;
            cnt_next   = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_next = REL_BUS;
                        cnt_next   = '0;
                    end
                end
                REL_BUS: begin
                    if (cnt == GAP_LAST) begin
                        state_next = REL_IC;
                        cnt_next   = '0;
                    end
                end
                REL_IC: begin
                    if (cnt == GAP_LAST) begin
                        state_next    = RUN;
                        cnt_next      = '0;
                        count_release = 1'b1;
                    end
                end
                RUN: begin
                    cnt_next = '0;
                end
                default: begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so every stage flips on the same edge as the FSM.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state                <= HOLD;
            cnt                  <= '0;
            release_count        <= 8'd0;
            bus_struct_reset     <= 1'b1;
            interconnect_aresetn <= 1'b0;
            peripheral_aresetn   <= 1'b0;
            peripheral_reset     <= 1'b1;
            seq_done             <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (count_release && (release_count != 8'hFF)) begin
                release_count <= release_count + 8'd1;
            end
            bus_struct_reset     <= (state_next == HOLD);
            interconnect_aresetn <= (state_next == REL_IC) || (state_next == RUN);
            peripheral_aresetn   <= (state_next == RUN);
            peripheral_reset     <= (state_next != RUN);
            seq_done             <= (state_next == RUN);
        end
    end

endmodule

// File: tb/tb_pl_reset_sequencer.sv
// Bench for pl_reset_sequencer: directed timing scenarios plus random input activity,
// all checked against a model built from input history and a clean-run length.
module tb_pl_reset_sequencer;

    localparam int SYNC_STAGES = 2;
    localparam int LOCK_FILTER = 8;
    localparam int HOLD_CYCLES = 16;
    localparam int STAGE_GAP   = 4;
    localparam int HIST        = 64;
    localparam int RUN_AT      = HOLD_CYCLES + 2 * STAGE_GAP;

    logic       clk_in1 = 1'b0;
    logic       reset;
    logic       ext_reset_in;
    logic       dcm_locked;
    logic       bus_struct_reset;
    logic       interconnect_aresetn;
    logic       peripheral_aresetn;
    logic       peripheral_reset;
    logic       seq_done;
    logic [7:0] release_count;

    pl_reset_sequencer #(
        .SYNC_STAGES(SYNC_STAGES),
        .LOCK_FILTER(LOCK_FILTER),
        .HOLD_CYCLES(HOLD_CYCLES),
        .STAGE_GAP  (STAGE_GAP)
    ) dut (
        .clk_in1             (clk_in1),
        .reset               (reset),
        .ext_reset_in        (ext_reset_in),
        .dcm_locked          (dcm_locked),
        .bus_struct_reset    (bus_struct_reset),
        .interconnect_aresetn(interconnect_aresetn),
        .peripheral_aresetn  (peripheral_aresetn),
        .peripheral_reset    (peripheral_reset),
        .seq_done            (seq_done),
        .release_count       (release_count)
    );

    always #5 clk_in1 = ~clk_in1;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;
    int clean_run   = 0;
    int exp_count   = 0;

    bit hist_rst [HIST];
    bit hist_ext [HIST];
    bit hist_lock[HIST];

    function automatic int slot(int x);
        return ((x % HIST) + HIST) % HIST;
    endfunction

    // A synchronized input is the raw value SYNC_STAGES edges back, unless a reset intervened.
    function automatic bit synced(bit is_lock, int x);
        bit v;
        v = is_lock ? hist_lock[slot(x - SYNC_STAGES)] : hist_ext[slot(x - SYNC_STAGES)];
        for (int y = x - SYNC_STAGES; y < x; y++) begin
            if (hist_rst[slot(y)]) v = 1'b0;
        end
        return v;
    endfunction

    function automatic bit lock_good(int x);
        for (int k = 0; k < LOCK_FILTER; k++) begin
            if (!synced(1'b1, x - k)) return 1'b0;
        end
        for (int y = x - LOCK_FILTER + 1; y < x; y++) begin
            if (hist_rst[slot(y)]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: observed %0d, expected %0d",
                     tag, cyc, observed, expected);
        end
    endtask

    // One clock: the model advances on the edge, outputs are compared on the falling edge.
    task automatic applyStimulus();
        @(posedge clk_in1);
        cyc++;
        hist_rst[slot(cyc)]  = reset;
        hist_ext[slot(cyc)]  = ext_reset_in;
        hist_lock[slot(cyc)] = dcm_locked;
        if (reset) begin
            clean_run = 0;
            exp_count = 0;
        end else if (!synced(1'b0, cyc) || !lock_good(cyc)) begin
            clean_run = 0;
        end else begin
            if (clean_run < 1000000) clean_run++;
            if (clean_run == RUN_AT && exp_count < 255) exp_count++;
        end
        @(negedge clk_in1);
        checkOutput("bus_struct_reset", bus_struct_reset, clean_run < HOLD_CYCLES);
        checkOutput("interconnect_aresetn", interconnect_aresetn,
                    clean_run >= HOLD_CYCLES + STAGE_GAP);
        checkOutput("peripheral_aresetn", peripheral_aresetn, clean_run >= RUN_AT);
        checkOutput("peripheral_reset", peripheral_reset, clean_run < RUN_AT);
        checkOutput("seq_done", seq_done, clean_run >= RUN_AT);
        checkOutput("release_count", release_count, exp_count);
    endtask

    task automatic runUntil(input int target);
        while (cyc < target) applyStimulus();
    endtask

    // Drop ext_reset_in for a few cycles and return the edge at which it rises again.
    task automatic restartSequence(output int rise_edge);
        ext_reset_in = 1'b0;
        runUntil(cyc + 3);
        ext_reset_in = 1'b1;
        rise_edge = cyc;
    endtask

    initial begin
        int e;
        int t0;
        int r;

        for (int i = 0; i < HIST; i++) begin
            hist_rst[i]  = 1'b1;
            hist_ext[i]  = 1'b0;
            hist_lock[i] = 1'b0;
        end

        $display("[TB] power-up");
        reset        = 1'b1;
        ext_reset_in = 1'b0;
        dcm_locked   = 1'b1;
        runUntil(3);
        checkOutput("rst_bus", bus_struct_reset, 1);
        checkOutput("rst_ic", interconnect_aresetn, 0);
        checkOutput("rst_per_n", peripheral_aresetn, 0);
        checkOutput("rst_per", peripheral_reset, 1);
        checkOutput("rst_done", seq_done, 0);
        checkOutput("rst_count", release_count, 0);
        runUntil(5);
        reset = 1'b0;
        runUntil(20);
        ext_reset_in = 1'b1;
        runUntil(37);
        checkOutput("pwr_bus_37", bus_struct_reset, 1);
        runUntil(38);
        checkOutput("pwr_bus_38", bus_struct_reset, 0);
        runUntil(41);
        checkOutput("pwr_ic_41", interconnect_aresetn, 0);
        runUntil(42);
        checkOutput("pwr_ic_42", interconnect_aresetn, 1);
        runUntil(45);
        checkOutput("pwr_per_45", peripheral_aresetn, 0);
        runUntil(46);
        checkOutput("pwr_per_46", peripheral_aresetn, 1);
        checkOutput("pwr_done_46", seq_done, 1);
        checkOutput("pwr_count_46", release_count, 1);
        runUntil(60);

        $display("[TB] late lock");
        reset      = 1'b1;
        dcm_locked = 1'b0;
        runUntil(cyc + 3);
        reset = 1'b0;
        runUntil(cyc + 7);
        e = cyc;
        dcm_locked = 1'b1;
        runUntil(e + 24);
        checkOutput("late_bus_pre", bus_struct_reset, 1);
        runUntil(e + 25);
        checkOutput("late_bus", bus_struct_reset, 0);
        runUntil(e + 32);
        checkOutput("late_per_pre", peripheral_aresetn, 0);
        runUntil(e + 33);
        checkOutput("late_per", peripheral_aresetn, 1);
        checkOutput("late_count", release_count, 1);
        runUntil(e + 40);

        $display("[TB] lock loss in RUN");
        e = cyc;
        dcm_locked = 1'b0;
        runUntil(e + 2);
        checkOutput("loss_per_hold", peripheral_aresetn, 1);
        runUntil(e + 3);
        checkOutput("loss_per", peripheral_aresetn, 0);
        checkOutput("loss_bus", bus_struct_reset, 1);
        checkOutput("loss_done", seq_done, 0);
        runUntil(e + 6);
        dcm_locked = 1'b1;
        runUntil(cyc + 40);
        checkOutput("relock_count", release_count, 2);

        $display("[TB] glitch during HOLD");
        restartSequence(e);
        t0 = e + SYNC_STAGES;
        runUntil(t0 + 10);
        ext_reset_in = 1'b0;
        runUntil(t0 + 11);
        ext_reset_in = 1'b1;
        runUntil(t0 + 28);
        checkOutput("glitch_bus_hold", bus_struct_reset, 1);
        runUntil(t0 + 29);
        checkOutput("glitch_bus_rel", bus_struct_reset, 0);
        runUntil(t0 + 36);
        checkOutput("glitch_per_pre", peripheral_aresetn, 0);
        runUntil(t0 + 37);
        checkOutput("glitch_per", peripheral_aresetn, 1);
        checkOutput("glitch_count", release_count, 3);

        $display("[TB] reset in REL_IC");
        restartSequence(e);
        t0 = e + SYNC_STAGES;
        runUntil(t0 + 20);
        checkOutput("mid_ic", interconnect_aresetn, 1);
        checkOutput("mid_per", peripheral_aresetn, 0);
        reset = 1'b1;
        r = t0 + 21;
        runUntil(r);
        reset = 1'b0;
        checkOutput("mid_rst_bus", bus_struct_reset, 1);
        checkOutput("mid_rst_ic", interconnect_aresetn, 0);
        checkOutput("mid_rst_count", release_count, 0);
        runUntil(r + 32);
        checkOutput("mid_reseq_pre", peripheral_aresetn, 0);
        runUntil(r + 33);
        checkOutput("mid_reseq_per", peripheral_aresetn, 1);
        checkOutput("mid_reseq_count", release_count, 1);

        $display("[TB] saturation");
        for (int n = 0; n < 260; n++) begin
            dcm_locked = 1'b0;
            runUntil(cyc + 4);
            dcm_locked = 1'b1;
            runUntil(cyc + 36);
        end
        checkOutput("sat_count", release_count, 255);
        checkOutput("sat_done", seq_done, 1);

        $display("[TB] random activity");
        for (int n = 0; n < 3000; n++) begin
            if (ext_reset_in) ext_reset_in = ($urandom_range(0, 99) >= 2);
            else              ext_reset_in = ($urandom_range(0, 99) < 30);
            if (dcm_locked)   dcm_locked   = ($urandom_range(0, 99) >= 2);
            else              dcm_locked   = ($urandom_range(0, 99) < 30);
            reset = ($urandom_range(0, 199) == 0);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
